empty_ptr_allocator: RTL and testbench

Owns the pool of free data-table addresses for the hash table. It hands out one free address at a time to the insert path and takes freed addresses back from the delete path. The free list is a circular FIFO in RAM and is filled with every address after reset. Its add/del strobes are the ones the table monitor cross-checks.

---
 rtl/hash_table_pkg.sv | 5 +
 rtl/simple_dual_port_ram.sv | 29 ++
 rtl/empty_ptr_allocator.sv | 137 +++++++++++++
 tb/tb_empty_ptr_allocator.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hash_table_pkg.sv
// Shared hash-table definitions: data-table address width and pointer type.
package hash_table;
    localparam int TABLE_ADDR_WIDTH = 8;
    typedef logic [TABLE_ADDR_WIDTH-1:0] table_ptr_t;
endpackage

// File: rtl/simple_dual_port_ram.sv
// Plain inferable simple dual-port RAM: one write port, one registered read port.
module simple_dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/empty_ptr_allocator.sv
// Free-address pool for the hash data table: a RAM-backed circular FIFO filled
// with every address after reset, presenting one show-ahead head entry.
module empty_ptr_allocator #(
    parameter int TABLE_ADDR_WIDTH = hash_table::TABLE_ADDR_WIDTH
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [TABLE_ADDR_WIDTH-1:0] add_addr_i,
    input  logic                        add_addr_en_i,
    input  logic                        del_addr_en_i,
    output logic [TABLE_ADDR_WIDTH-1:0] next_empty_addr_o,
    output logic                        next_empty_addr_val_o,
    output logic [TABLE_ADDR_WIDTH:0]   empty_cnt_o,
    output logic                        init_done_o,
    output logic                        push_err_o,
    output logic                        pop_err_o
);

    localparam int AW = TABLE_ADDR_WIDTH;

    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam logic [AW:0]   POOL_SIZE = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW-1:0] PTR_LAST  = '1;

    // Handshake: a pop is taken when del_addr_en_i and next_empty_addr_val_o are
    // both high in the same cycle; a push is taken when add_addr_en_i is high,
    // the fill is done and the pool is not full. Anything else that is strobed
    // is dropped and reported one cycle later on the matching *_err_o pulse.

    logic [0:0]    state_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW:0]   ram_cnt_q;
    logic [AW:0]   empty_cnt_q;
    logic          head_valid_q;
    logic          init_done_q;
    logic          push_err_q;
    logic          pop_err_q;

    logic          pop_ok;
    logic          push_ok;
    logic          prefetch;
    logic          init_last;
    logic          ram_we;
    logic [AW-1:0] ram_wdata;
    logic [AW-1:0] ram_rdata;
    logic          head_valid_d;
    logic [AW:0]   ram_cnt_d;
    logic [AW:0]   empty_cnt_d;

    always_comb begin
        pop_ok    = del_addr_en_i && head_valid_q;
        push_ok   = add_addr_en_i && (state_q == ST_READY) && (empty_cnt_q < POOL_SIZE);
        prefetch  = (state_q == ST_READY) && !head_valid_q && (ram_cnt_q != '0);
        init_last = (state_q == ST_INIT) && (wr_ptr_q == PTR_LAST);
        // The fill reuses the write port, with wr_ptr doubling as the fill counter.
        ram_we    = (state_q == ST_INIT) || push_ok;
        ram_wdata = (state_q == ST_INIT) ? wr_ptr_q : add_addr_i;

        head_valid_d = head_valid_q;
        if (prefetch) begin
            head_valid_d = 1'b1;
        end else if (pop_ok) begin
            head_valid_d = 1'b0;
        end

        ram_cnt_d = ram_cnt_q;
        if (init_last) begin
            ram_cnt_d = POOL_SIZE;
        end else begin
            if (push_ok) begin
                ram_cnt_d = ram_cnt_d + CNT_ONE;
            end
            if (prefetch) begin
                ram_cnt_d = ram_cnt_d - CNT_ONE;
            end
        end

        empty_cnt_d = ram_cnt_d + {{AW{1'b0}}, head_valid_d};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_INIT;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            ram_cnt_q    <= '0;
            empty_cnt_q  <= '0;
            head_valid_q <= 1'b0;
            init_done_q  <= 1'b0;
            push_err_q   <= 1'b0;
            pop_err_q    <= 1'b0;
        end else begin
            if (init_last) begin
                state_q     <= ST_READY;
                init_done_q <= 1'b1;
            end
            if (ram_we) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (prefetch) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
            ram_cnt_q    <= ram_cnt_d;
            empty_cnt_q  <= empty_cnt_d;
            head_valid_q <= head_valid_d;
            push_err_q   <= add_addr_en_i && !push_ok;
            pop_err_q    <= del_addr_en_i && !pop_ok;
        end
    end

    // The RAM read register is the head register; it has no reset, so gate it.
    simple_dual_port_ram #(
        .DATA_WIDTH(AW),
        .ADDR_WIDTH(AW)
    ) u_free_list_ram (
        .clk_i    (clk_i),
        .wr_en_i  (ram_we),
        .wr_addr_i(wr_ptr_q),
        .wr_data_i(ram_wdata),
        .rd_en_i  (prefetch),
        .rd_addr_i(rd_ptr_q),
        .rd_data_o(ram_rdata)
    );

    assign next_empty_addr_o     = head_valid_q ? ram_rdata : '0;
    assign next_empty_addr_val_o = head_valid_q;
    assign empty_cnt_o           = empty_cnt_q;
    assign init_done_o           = init_done_q;
    assign push_err_o            = push_err_q;
    assign pop_err_o             = pop_err_q;

endmodule

// File: tb/tb_empty_ptr_allocator.sv
// Self-checking bench for empty_ptr_allocator with a 16-entry pool.
module tb_empty_ptr_allocator;

    localparam int AW = 4;
    localparam int N  = 16;

    logic          clk_i;
    logic          rst_i;
    logic [AW-1:0] add_addr_i;
    logic          add_addr_en_i;
    logic          del_addr_en_i;
    logic [AW-1:0] next_empty_addr_o;
    logic          next_empty_addr_val_o;
    logic [AW:0]   empty_cnt_o;
    logic          init_done_o;
    logic          push_err_o;
    logic          pop_err_o;

    empty_ptr_allocator #(.TABLE_ADDR_WIDTH(AW)) dut (
        .clk_i                (clk_i),
        .rst_i                (rst_i),
        .add_addr_i           (add_addr_i),
        .add_addr_en_i        (add_addr_en_i),
        .del_addr_en_i        (del_addr_en_i),
        .next_empty_addr_o    (next_empty_addr_o),
        .next_empty_addr_val_o(next_empty_addr_val_o),
        .empty_cnt_o          (empty_cnt_o),
        .init_done_o          (init_done_o),
        .push_err_o           (push_err_o),
        .pop_err_o            (pop_err_o)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    int tb_cyc = 0;

    // ---------------- reference model ----------------
    // The pool is an ordered list of free addresses, head first.
    logic [AW-1:0] exp_q[$];
    int  m_cyc;
    bit  m_val;
    bit  m_push_err;
    bit  m_pop_err;

    logic [AW-1:0] got_q[$];
    int            pop_cyc_q[$];

    typedef struct {
        logic          add_en;
        logic [AW-1:0] add_addr;
        logic          del_en;
        logic          exp_val;
        logic [AW-1:0] exp_addr;
        logic [AW:0]   exp_cnt;
        logic          exp_push_err;
        logic          exp_pop_err;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, m_cyc);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        m_cyc      = 0;
        m_val      = 1'b0;
        m_push_err = 1'b0;
        m_pop_err  = 1'b0;
    endfunction

    function automatic void model_advance(input bit a_en, input logic [AW-1:0] a_addr, input bit d_en);
        bit ready;
        int size0;
        ready      = (m_cyc >= N);
        size0      = exp_q.size();
        m_pop_err  = d_en && !m_val;
        m_push_err = a_en && !(ready && size0 < N);
        if (d_en && m_val) begin
            void'(exp_q.pop_front());
            m_val = 1'b0;
        end else if (ready && !m_val && size0 > 0) begin
            m_val = 1'b1;
        end
        if (a_en && ready && size0 < N) exp_q.push_back(a_addr);
        m_cyc++;
        if (m_cyc == N) begin
            for (int i = 0; i < N; i++) exp_q.push_back(AW'(i));
        end
    endfunction

    task automatic check_model();
        chk("init_done", int'(init_done_o), int'(m_cyc >= N));
        chk("empty_cnt", int'(empty_cnt_o), exp_q.size());
        chk("val", int'(next_empty_addr_val_o), int'(m_val));
        chk("addr", int'(next_empty_addr_o), m_val ? int'(exp_q[0]) : 0);
        chk("push_err", int'(push_err_o), int'(m_push_err));
        chk("pop_err", int'(pop_err_o), int'(m_pop_err));
    endtask

    // ---------------- driver tasks ----------------
    // Called at a falling edge; drives one cycle of inputs, then samples the next cycle.
    task automatic tick(input bit a_en, input logic [AW-1:0] a_addr, input bit d_en);
        add_addr_en_i = a_en;
        add_addr_i    = a_addr;
        del_addr_en_i = d_en;
        model_advance(a_en, a_addr, d_en);
        @(negedge clk_i);
        tb_cyc++;
        add_addr_en_i = 1'b0;
        del_addr_en_i = 1'b0;
        check_model();
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("rst_val", int'(next_empty_addr_val_o), 0);
        chk("rst_addr", int'(next_empty_addr_o), 0);
        chk("rst_cnt", int'(empty_cnt_o), 0);
        chk("rst_init", int'(init_done_o), 0);
        chk("rst_errs", int'(push_err_o) + int'(pop_err_o), 0);
        model_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check_model();
    endtask

    task automatic wait_ready();
        for (int c = 0; c < N + 1; c++) tick(0, '0, 0);
    endtask

    task automatic drain(input int n, input int budget);
        int popped;
        popped = 0;
        got_q.delete();
        pop_cyc_q.delete();
        for (int i = 0; i < budget && popped < n; i++) begin
            if (next_empty_addr_val_o) begin
                got_q.push_back(next_empty_addr_o);
                pop_cyc_q.push_back(tb_cyc);
                popped++;
                tick(0, '0, 1);
            end else begin
                tick(0, '0, 0);
            end
        end
        chk("drain_count", popped, n);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        rst_i         = 1'b1;
        add_addr_i    = '0;
        add_addr_en_i = 1'b0;
        del_addr_en_i = 1'b0;
        model_reset();

        // Scenarios 1 and 4b: fill timing, with a push and a pop during INIT.
        do_reset();
        for (int c = 0; c < N + 1; c++) begin
            if (c == 6) chk("init_push_err", int'(push_err_o), 1);
            if (c == 8) chk("init_pop_err", int'(pop_err_o), 1);
            if (c == N - 1) chk("init_not_done_15", int'(init_done_o), 0);
            if (c == N) begin
                chk("init_done_16", int'(init_done_o), 1);
                chk("init_cnt_16", int'(empty_cnt_o), N);
                chk("init_val_16", int'(next_empty_addr_val_o), 0);
            end
            tick(c == 5, AW'(9), c == 7);
        end
        chk("first_val_17", int'(next_empty_addr_val_o), 1);
        chk("first_addr_17", int'(next_empty_addr_o), 0);

        // Scenario 2: drain the initial pool in order, one pop every 2 cycles.
        drain(N, 4 * N);
        for (int i = 0; i < got_q.size(); i++) chk("drain_order", int'(got_q[i]), i);
        for (int i = 1; i < pop_cyc_q.size(); i++) chk("drain_gap", pop_cyc_q[i] - pop_cyc_q[i-1], 2);
        tick(0, '0, 0);
        chk("drained_cnt", int'(empty_cnt_o), 0);
        chk("drained_val", int'(next_empty_addr_val_o), 0);
        tick(0, '0, 1);
        chk("extra_pop_err", int'(pop_err_o), 1);
        chk("extra_pop_cnt", int'(empty_cnt_o), 0);

        // Scenario 3: refill from empty with 5 then 9.
        tick(1, AW'(5), 0);
        chk("refill_val_t1", int'(next_empty_addr_val_o), 0);
        tick(1, AW'(9), 0);
        chk("refill_val_t2", int'(next_empty_addr_val_o), 1);
        chk("refill_addr5", int'(next_empty_addr_o), 5);
        chk("refill_cnt2", int'(empty_cnt_o), 2);
        tick(0, '0, 1);
        chk("refill_cnt1", int'(empty_cnt_o), 1);
        tick(0, '0, 0);
        chk("refill_addr9", int'(next_empty_addr_o), 9);
        tick(0, '0, 1);
        chk("refill_cnt0", int'(empty_cnt_o), 0);

        // Scenario 5: simultaneous push and pop with three entries held.
        tick(1, AW'(1), 0);
        tick(1, AW'(2), 0);
        tick(1, AW'(4), 0);
        for (int i = 0; i < 8 && !next_empty_addr_val_o; i++) tick(0, '0, 0);
        chk("pp_pre_cnt", int'(empty_cnt_o), 3);
        chk("pp_pre_head", int'(next_empty_addr_o), 1);
        tick(1, AW'(7), 1);
        chk("pp_cnt_same", int'(empty_cnt_o), 3);
        drain(3, 20);
        for (int i = 0; i < got_q.size(); i++) chk("pp_order", int'(got_q[i]), (i == 0) ? 2 : (i == 1) ? 4 : 7);

        // Scenario 4a and friends: table-driven vectors from a fresh full pool.
        vecs[0] = '{1'b1, AW'(3), 1'b0, 1'b1, AW'(0), 5'd16, 1'b1, 1'b0};
        vecs[1] = '{1'b0, AW'(0), 1'b1, 1'b0, AW'(0), 5'd15, 1'b0, 1'b0};
        vecs[2] = '{1'b0, AW'(0), 1'b1, 1'b1, AW'(1), 5'd15, 1'b0, 1'b1};
        vecs[3] = '{1'b1, AW'(0), 1'b1, 1'b0, AW'(0), 5'd15, 1'b0, 1'b0};
        vecs[4] = '{1'b0, AW'(0), 1'b0, 1'b1, AW'(2), 5'd15, 1'b0, 1'b0};
        do_reset();
        wait_ready();
        for (int i = 0; i < 5; i++) begin
            tick(vecs[i].add_en, vecs[i].add_addr, vecs[i].del_en);
            chk("vec_val", int'(next_empty_addr_val_o), int'(vecs[i].exp_val));
            chk("vec_addr", int'(next_empty_addr_o), int'(vecs[i].exp_addr));
            chk("vec_cnt", int'(empty_cnt_o), int'(vecs[i].exp_cnt));
            chk("vec_push_err", int'(push_err_o), int'(vecs[i].exp_push_err));
            chk("vec_pop_err", int'(pop_err_o), int'(vecs[i].exp_pop_err));
        end

        // Scenario 6: reset after four more pops, then a clean re-init.
        drain(4, 20);
        do_reset();
        wait_ready();
        chk("reinit_cnt", int'(empty_cnt_o), N);
        chk("reinit_addr", int'(next_empty_addr_o), 0);
        chk("reinit_val", int'(next_empty_addr_val_o), 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick($urandom_range(0, 99) < 45, AW'($urandom_range(0, N - 1)), $urandom_range(0, 99) < 50);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

endmodule
